// File: rtl/exception_ctrl_unit.sv
// Sequential exception controller: prioritised capture of EPC/cause, timed flush, vector redirect, return and double-fault lockup.
// Optional build macro EXC_COUNTER_EN adds a saturating exception counter (exc_count) with synchronous clear (exc_count_clr).

module exception_ctrl_unit #(
    parameter int                 INSTR_W       = 16,
    parameter int                 ADDR_W        = 16,
    parameter int                 NUM_EXT       = 2,
    parameter logic [15:0]        VALID_OP_MASK = 16'h7FFF,
    parameter logic [15:0]        ARITH_OP_MASK = 16'h0007,
    parameter int                 FLUSH_CYCLES  = 2,
    parameter logic [ADDR_W-1:0]  VECTOR_BASE   = 16'h0100,
    parameter logic [ADDR_W-1:0]  VEC_STRIDE    = 16'h0010
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  instruct,
    input  logic                instr_valid,
    input  logic                overflow,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [NUM_EXT-1:0]  ext_req,
    input  logic                eret,
    output logic                exception_flag,
    output logic                flush,
    output logic [1:0]          pc_sel,
    output logic [ADDR_W-1:0]   vector_pc,
    output logic [ADDR_W-1:0]   epc,
    output logic [3:0]          cause,
    output logic                busy,
    output logic                halted
`ifdef EXC_COUNTER_EN
    ,
    input  logic                exc_count_clr,
    output logic [7:0]          exc_count
`endif
);

    // state    | meaning
    // S_IDLE   | normal execution, watching for events
    // S_FLUSH  | pipeline flush, FLUSH_CYCLES long
    // S_VECTOR | one-cycle redirect to the handler vector
    // S_HANDLER| handler running, waiting for eret
    // S_RETURN | one-cycle redirect back to epc
    // S_HALT   | double-fault lockup, exit by reset only
    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_VECTOR,
        S_HANDLER,
        S_RETURN,
        S_HALT
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          flush_cnt;
    logic [NUM_EXT-1:0]  pend;
    logic [NUM_EXT-1:0]  pend_all;
    logic [NUM_EXT-1:0]  ext_hit;
    logic [3:0]          ext_code;
    logic [3:0]          op;
    logic                illegal;
    logic                ovf;
    logic                take;
    logic [3:0]          take_code;
    logic                take_ext;
    logic                capture_pc;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instruct[INSTR_W-5:0];

    function automatic logic [ADDR_W-1:0] vec_addr(input logic [3:0] code);
        return VECTOR_BASE + ADDR_W'(code) * VEC_STRIDE;
    endfunction

    assign op       = instruct[INSTR_W-1 -: 4];
    assign illegal  = instr_valid & ~VALID_OP_MASK[op];
    assign ovf      = instr_valid & overflow & ARITH_OP_MASK[op];
    assign pend_all = pend | ext_req;

    // Lowest index wins, so scan from the top and let lower bits overwrite.
    always_comb begin
        ext_hit  = '0;
        ext_code = 4'd0;
        for (int k = NUM_EXT - 1; k >= 0; k--) begin
            if (pend_all[k]) begin
                ext_hit    = '0;
                ext_hit[k] = 1'b1;
                ext_code   = 4'(3 + k);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        take       = 1'b0;
        take_code  = 4'd0;
        take_ext   = 1'b0;
        capture_pc = 1'b0;
        case (state)
            S_IDLE: begin
                if (illegal) begin
                    take       = 1'b1;
                    take_code  = 4'd1;
                    capture_pc = 1'b1;
                end else if (ovf) begin
                    take       = 1'b1;
                    take_code  = 4'd2;
                    capture_pc = 1'b1;
                end else if (|pend_all) begin
                    take       = 1'b1;
                    take_ext   = 1'b1;
                    take_code  = ext_code;
                    capture_pc = instr_valid;
                end
                if (take) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt == 4'd0) state_nxt = S_VECTOR;
            end
            S_VECTOR:  state_nxt = S_HANDLER;
            S_HANDLER: begin
                if (eret)                  state_nxt = S_RETURN;
                else if (illegal || ovf)   state_nxt = S_HALT;
            end
            S_RETURN:  state_nxt = S_IDLE;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign flush  = (state == S_FLUSH) || (state == S_RETURN) || (state == S_HALT);
    assign pc_sel = (state == S_VECTOR) ? 2'b01 :
                    (state == S_RETURN) ? 2'b10 : 2'b00;
    assign busy   = (state != S_IDLE);
    assign halted = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pend           <= '0;
            flush_cnt      <= 4'd0;
            epc            <= '0;
            cause          <= 4'd0;
            vector_pc      <= '0;
            exception_flag <= 1'b0;
        end else begin
            state          <= state_nxt;
            exception_flag <= take;
            // Requests arriving while locked up are dropped.
            if (state != S_HALT)
                pend <= pend_all & ~(take_ext ? ext_hit : '0);
            if (take)
                flush_cnt <= 4'(FLUSH_CYCLES - 1);
            else if (state == S_FLUSH && flush_cnt != 4'd0)
                flush_cnt <= flush_cnt - 4'd1;
            if (take && capture_pc)
                epc <= pc;
            if (take) begin
                cause     <= take_code;
                vector_pc <= vec_addr(take_code);
            end else if (state == S_RETURN) begin
                cause <= 4'd0;
            end
        end
    end

`ifdef EXC_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exc_count <= 8'd0;
        else if (exc_count_clr)
            exc_count <= 8'd0;
        else if (exception_flag && exc_count != 8'hFF)
            exc_count <= exc_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_exception_ctrl_unit.sv
// Bench for exception_ctrl_unit: vector table, directed corner sequences, and random traffic against a timeline model.

module tb_exception_ctrl_unit;

    localparam int F = 2;
    localparam logic [15:0] VALID_MASK = 16'h7FFF;
    localparam logic [15:0] ARITH_MASK = 16'h0007;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruct;
    logic        instr_valid;
    logic        overflow;
    logic [15:0] pc;
    logic [1:0]  ext_req;
    logic        eret;
    logic        exception_flag;
    logic        flush;
    logic [1:0]  pc_sel;
    logic [15:0] vector_pc;
    logic [15:0] epc;
    logic [3:0]  cause;
    logic        busy;
    logic        halted;
`ifdef EXC_COUNTER_EN
    logic        exc_count_clr;
    logic [7:0]  exc_count;
`endif

    int checks;
    int failures;

    exception_ctrl_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruct       (instruct),
        .instr_valid    (instr_valid),
        .overflow       (overflow),
        .pc             (pc),
        .ext_req        (ext_req),
        .eret           (eret),
        .exception_flag (exception_flag),
        .flush          (flush),
        .pc_sel         (pc_sel),
        .vector_pc      (vector_pc),
        .epc            (epc),
        .cause          (cause),
        .busy           (busy),
        .halted         (halted)
`ifdef EXC_COUNTER_EN
        ,
        .exc_count_clr  (exc_count_clr),
        .exc_count      (exc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_age counts edges since an exception was taken (1 = first flush cycle,
    // F+1 = vector cycle, F+2 = handler); -1 when no exception is in flight.
    int          m_age;
    bit          m_ret;
    bit          m_halt;
    logic [1:0]  m_pend;
    logic [15:0] m_epc;
    logic [15:0] m_vec;
    logic [3:0]  m_cause;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] dut_vec();
        return {exception_flag, flush, pc_sel, busy, halted, cause, epc};
    endfunction

    function automatic logic [25:0] model_vec();
        logic       e_flag, e_flush, e_busy;
        logic [1:0] e_psel;
        e_flag  = (m_age == 1);
        e_flush = (m_age >= 1 && m_age <= F) || m_ret || m_halt;
        e_psel  = (m_age == F + 1) ? 2'b01 : (m_ret ? 2'b10 : 2'b00);
        e_busy  = m_halt || m_ret || (m_age >= 1);
        return {e_flag, e_flush, e_psel, e_busy, logic'(m_halt), m_cause, m_epc};
    endfunction

    task automatic model_reset();
        m_age = -1; m_ret = 0; m_halt = 0;
        m_pend = '0; m_epc = '0; m_vec = '0; m_cause = '0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [3:0] op;
        bit         ill, ov;
        logic [1:0] p;
        int         code;
        op  = instruct[15:12];
        ill = instr_valid && !VALID_MASK[op];
        ov  = instr_valid && overflow && ARITH_MASK[op];
`ifdef EXC_COUNTER_EN
        if (exc_count_clr) m_cnt = 0;
        else if (m_age == 1 && m_cnt < 255) m_cnt++;
`endif
        if (!m_halt) begin
            p = m_pend | ext_req;
            if (m_ret) begin
                m_ret   = 0;
                m_cause = 4'd0;
            end else if (m_age < 0) begin
                code = 0;
                if (ill) code = 1;
                else if (ov) code = 2;
                else begin
                    for (int k = 0; k < 2; k++)
                        if (code == 0 && p[k]) begin
                            code = 3 + k;
                            p[k] = 1'b0;
                        end
                end
                if (code != 0) begin
                    m_age   = 1;
                    m_cause = 4'(code);
                    m_vec   = 16'(256 + code * 16);
                    if (code <= 2 || instr_valid) m_epc = pc;
                end
            end else if (m_age <= F + 1) begin
                m_age++;
            end else begin
                if (eret) begin
                    m_ret = 1; m_age = -1;
                end else if (ill || ov) begin
                    m_halt = 1; m_age = -1;
                end
            end
            m_pend = p;
        end
    endtask

    task automatic compare_model();
        chk("model_outputs", 32'(dut_vec()), 32'(model_vec()));
        if (m_age == F + 1) chk("model_vector_pc", 32'(vector_pc), 32'(m_vec));
`ifdef EXC_COUNTER_EN
        chk("model_exc_count", 32'(exc_count), 32'(m_cnt));
`endif
    endtask

    task automatic step(input logic [15:0] i_instr, input logic i_iv, input logic i_ov,
                        input logic [15:0] i_pc, input logic [1:0] i_ext, input logic i_eret);
        instruct = i_instr; instr_valid = i_iv; overflow = i_ov;
        pc = i_pc; ext_req = i_ext; eret = i_eret;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle_step(input logic [15:0] i_pc);
        step(16'h0123, 1'b0, 1'b0, i_pc, 2'b00, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("reset_outputs", 32'({dut_vec(), vector_pc[5:0]}), 32'd0);
`ifdef EXC_COUNTER_EN
        chk("reset_exc_count", 32'(exc_count), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        iv;
        logic        ov;
        logic [15:0] pc;
        logic [1:0]  ext;
        logic        eret;
        logic        e_flag;
        logic        e_flush;
        logic [1:0]  e_psel;
        logic [3:0]  e_cause;
        logic        e_busy;
        logic [15:0] e_epc;
        logic [15:0] e_vec;
    } vec_t;

    vec_t tbl[14];
    int   halt_cycles;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        instruct = 16'h0123; instr_valid = 1'b0; overflow = 1'b0;
        pc = 16'h0000; ext_req = 2'b00; eret = 1'b0;
`ifdef EXC_COUNTER_EN
        exc_count_clr = 1'b0;
`endif
        model_reset();

        //            instr     iv ov pc        ext   er  flag fl psel  cause busy epc       vec
        tbl[0]  = '{16'hF123, 1, 0, 16'h0040, 2'b00, 0,  1, 1, 2'd0, 4'd1, 1, 16'h0040, 16'h0000};
        tbl[1]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 1, 2'd0, 4'd1, 1, 16'h0040, 16'h0000};
        tbl[2]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 0, 2'd1, 4'd1, 1, 16'h0040, 16'h0110};
        tbl[3]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 0, 2'd0, 4'd1, 1, 16'h0040, 16'h0000};
        tbl[4]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 1,  0, 1, 2'd2, 4'd1, 1, 16'h0040, 16'h0000};
        tbl[5]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 0, 2'd0, 4'd0, 0, 16'h0040, 16'h0000};
        tbl[6]  = '{16'h2123, 1, 1, 16'h0050, 2'b00, 0,  1, 1, 2'd0, 4'd2, 1, 16'h0050, 16'h0000};
        tbl[7]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 1, 2'd0, 4'd2, 1, 16'h0050, 16'h0000};
        tbl[8]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 0, 2'd1, 4'd2, 1, 16'h0050, 16'h0120};
        tbl[9]  = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 0, 2'd0, 4'd2, 1, 16'h0050, 16'h0000};
        tbl[10] = '{16'h0123, 0, 0, 16'h0000, 2'b00, 1,  0, 1, 2'd2, 4'd2, 1, 16'h0050, 16'h0000};
        tbl[11] = '{16'h0123, 0, 0, 16'h0000, 2'b00, 0,  0, 0, 2'd0, 4'd0, 0, 16'h0050, 16'h0000};
        tbl[12] = '{16'h5123, 1, 1, 16'h0060, 2'b00, 0,  0, 0, 2'd0, 4'd0, 0, 16'h0050, 16'h0000};
        tbl[13] = '{16'hF123, 0, 0, 16'h0070, 2'b00, 0,  0, 0, 2'd0, 4'd0, 0, 16'h0050, 16'h0000};

        #3;
        apply_reset();

        for (int r = 0; r < 14; r++) begin
            step(tbl[r].instr, tbl[r].iv, tbl[r].ov, tbl[r].pc, tbl[r].ext, tbl[r].eret);
            chk($sformatf("tbl_row%0d", r),
                32'({exception_flag, flush, pc_sel, cause, busy, epc}),
                32'({tbl[r].e_flag, tbl[r].e_flush, tbl[r].e_psel, tbl[r].e_cause,
                     tbl[r].e_busy, tbl[r].e_epc}));
            if (tbl[r].e_psel == 2'd1)
                chk($sformatf("tbl_vec%0d", r), 32'(vector_pc), 32'(tbl[r].e_vec));
        end

        // Reset landing in the middle of a flush.
        step(16'hF123, 1'b1, 1'b0, 16'h0040, 2'b00, 1'b0);
        chk("midflush_flush", 32'(flush), 32'd1);
        apply_reset();
        step(16'h0123, 1'b1, 1'b0, 16'h0044, 2'b00, 1'b0);
        chk("after_reset_busy", 32'(busy), 32'd0);

        // Internal fault beats both external requests, which then drain in index order.
        step(16'hF123, 1'b1, 1'b0, 16'h0040, 2'b11, 1'b0);
        chk("prio_cause_ill", 32'(cause), 32'd1);
        idle_step(16'h0000); idle_step(16'h0000); idle_step(16'h0000);
        step(16'h0123, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        idle_step(16'h0000);
        chk("prio_idle_gap", 32'(busy), 32'd0);
        idle_step(16'h0077);
        chk("prio_cause_ext0", 32'({cause, epc}), 32'({4'd3, 16'h0040}));
        idle_step(16'h0000); idle_step(16'h0000);
        chk("prio_vec_ext0", 32'({pc_sel, vector_pc}), 32'({2'b01, 16'h0130}));
        idle_step(16'h0000);
        step(16'h0123, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        idle_step(16'h0000);
        idle_step(16'h0000);
        chk("prio_cause_ext1", 32'(cause), 32'd4);
        idle_step(16'h0000); idle_step(16'h0000);
        chk("prio_vec_ext1", 32'({pc_sel, vector_pc}), 32'({2'b01, 16'h0140}));
        idle_step(16'h0000);
        step(16'h0123, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1);
        idle_step(16'h0000);
        chk("prio_drained", 32'({busy, cause}), 32'd0);

        // eret and fault together in the handler: return wins.
        step(16'h1123, 1'b1, 1'b1, 16'h0088, 2'b00, 1'b0);
        idle_step(16'h0000); idle_step(16'h0000); idle_step(16'h0000);
        step(16'hF123, 1'b1, 1'b0, 16'h0090, 2'b00, 1'b1);
        chk("eret_wins", 32'({halted, pc_sel}), 32'({1'b0, 2'b10}));
        idle_step(16'h0000);

        // Double fault locks up until reset.
        apply_reset();
        step(16'hF123, 1'b1, 1'b0, 16'h0040, 2'b00, 1'b0);
        idle_step(16'h0000); idle_step(16'h0000); idle_step(16'h0000);
        step(16'hF123, 1'b1, 1'b0, 16'h0099, 2'b00, 1'b0);
        chk("dfault_state", 32'({halted, flush, pc_sel, busy, cause, epc}),
            32'({1'b1, 1'b1, 2'b00, 1'b1, 4'd1, 16'h0040}));
        step(16'h0123, 1'b0, 1'b0, 16'h0000, 2'b01, 1'b1);
        step(16'h2123, 1'b1, 1'b1, 16'h00AA, 2'b00, 1'b1);
        chk("dfault_hold", 32'({halted, pc_sel, cause}), 32'({1'b1, 2'b00, 4'd1}));
`ifdef EXC_COUNTER_EN
        chk("dfault_count", 32'(exc_count), 32'd1);
`endif
        apply_reset();

        halt_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] r_instr;
            r_instr = 16'($urandom);
`ifdef EXC_COUNTER_EN
            exc_count_clr = ($urandom_range(0, 49) == 0);
`endif
            step(r_instr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 16'($urandom), (($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00),
                 ($urandom_range(0, 5) == 0));
            if (m_halt) halt_cycles++;
            if (halt_cycles > 4) begin
                halt_cycles = 0;
                apply_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
